// File: rtl/mips_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_ctrl_pkg
// Purpose  : Shared definitions for the MIPS pipeline control slice. It holds
//            the sequencer state encoding, the "operand not used" Tuse code,
//            the exception vector, the default MDU latencies and the RAW
//            hazard test for one source/producer pair.
// Revision : 1.0 - initial release
// ============================================================================
package mips_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN = 2'd0,
    MDU = 2'd1,
    EXC = 2'd2
  } ctrl_state_t;

  localparam logic [1:0]  TUSE_NONE        = 2'd3;
  localparam logic [31:0] EXC_VECTOR       = 32'h0000_4180;
  localparam int          DEF_MULT_CYCLES  = 5;
  localparam int          DEF_DIV_CYCLES   = 10;

  // RAW hazard between one D-stage source and one in-flight producer.
  // A result with Tnew==0 is always forwardable, and $0 is never a real
  // dependency. An unused operand cannot stall; the explicit TUSE_NONE
  // test keeps that intent readable.
  function automatic logic src_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] a3,
    input logic       we,
    input logic [1:0] tnew
  );
    return (src != 5'd0) && (tuse != TUSE_NONE) && we &&
           (a3 == src) && (tuse < tnew);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_busy_cnt.sv
`default_nettype none
// ============================================================================
// Module   : mdu_busy_cnt
// Purpose  : Multi-cycle MDU busy counter. A load (re)starts the count from
//            load_val, otherwise the count decrements to zero and stops.
// Ports    : clk, reset (sync, active-low), load, load_val[CNT_W-1:0]
//            busy - count is nonzero
//            last - count is 1 (final busy cycle)
// Revision : 1.0 - initial release
// ============================================================================
module mdu_busy_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             busy,
  output logic             last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      // A start while busy simply reloads: restart semantics.
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign busy = (cnt != '0);
  assign last = (cnt == CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_stall_ctrl
// Purpose  : Central pipeline sequencer for the 5-stage MIPS core. Detects
//            Tuse/Tnew data hazards and MDU hazards, owns the MDU busy
//            counter and the exception flush/redirect sequence, and drives
//            enable/flush for the F_D, D_E, E_M and M_W pipeline registers.
// Ports    : clk, reset (sync, active-low)
//            D hazard info : rs_D, rt_D, Tuse_rs_D, Tuse_rt_D, mdu_use_D
//            E producer    : A3_E, RegWrite_E, Tnew_E, mdu_start_E, mdu_div_E
//            M producer    : A3_M, RegWrite_M, Tnew_M, exc_M
//            Controls      : en_FD/DE/EM/MW, flush_FD/DE/EM/MW
//            Status        : mdu_busy, exc_redirect (PC loads EXC_VECTOR)
// Option   : HAZARD_PERF_CNT_EN adds stall_cycles[31:0] and exc_count[15:0]
//            saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  rs_D,
  input  logic [4:0]  rt_D,
  input  logic [1:0]  Tuse_rs_D,
  input  logic [1:0]  Tuse_rt_D,
  input  logic        mdu_use_D,
  input  logic [4:0]  A3_E,
  input  logic        RegWrite_E,
  input  logic [1:0]  Tnew_E,
  input  logic [4:0]  A3_M,
  input  logic        RegWrite_M,
  input  logic [1:0]  Tnew_M,
  input  logic        mdu_start_E,
  input  logic        mdu_div_E,
  input  logic        exc_M,
  output logic        en_FD,
  output logic        en_DE,
  output logic        en_EM,
  output logic        en_MW,
  output logic        flush_FD,
  output logic        flush_DE,
  output logic        flush_EM,
  output logic        flush_MW,
  output logic        mdu_busy,
  output logic        exc_redirect
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [15:0] exc_count
`endif
);

  ctrl_state_t state, state_next;

  logic             data_stall;
  logic             mdu_stall;
  logic             stall;
  logic             mdu_load;
  logic             mdu_last;
  logic             cnt_next_nz;
  logic [CNT_W-1:0] mdu_load_val;

  // --------------------------------------------------------------------------
  // Hazard detection
  // --------------------------------------------------------------------------
  assign data_stall = src_hazard(rs_D, Tuse_rs_D, A3_E, RegWrite_E, Tnew_E) |
                      src_hazard(rs_D, Tuse_rs_D, A3_M, RegWrite_M, Tnew_M) |
                      src_hazard(rt_D, Tuse_rt_D, A3_E, RegWrite_E, Tnew_E) |
                      src_hazard(rt_D, Tuse_rt_D, A3_M, RegWrite_M, Tnew_M);

  // The start cycle itself already blocks a following MDU instruction.
  assign mdu_stall = mdu_use_D & (mdu_busy | mdu_start_E);
  assign stall     = data_stall | mdu_stall;

  // --------------------------------------------------------------------------
  // MDU busy counter; an exception at M squashes the start in E.
  // --------------------------------------------------------------------------
  assign mdu_load     = mdu_start_E & ~exc_M;
  assign mdu_load_val = mdu_div_E ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

  mdu_busy_cnt #(
    .CNT_W (CNT_W)
  ) u_mdu_busy_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (mdu_load),
    .load_val (mdu_load_val),
    .busy     (mdu_busy),
    .last     (mdu_last)
  );

  // Counter value after the coming edge is nonzero.
  assign cnt_next_nz = mdu_load | (mdu_busy & ~mdu_last);

  // --------------------------------------------------------------------------
  // Sequencer FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (exc_M) begin
      state_next = EXC;
    end else begin
      case (state)
        RUN:     state_next = mdu_load ? MDU : RUN;
        MDU:     state_next = (mdu_last && !mdu_load) ? RUN : MDU;
        EXC:     state_next = cnt_next_nz ? MDU : RUN;
        default: state_next = RUN;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Pipeline register controls (combinational, no added latency)
  // --------------------------------------------------------------------------
  always_comb begin
    en_FD    = 1'b1;
    en_DE    = 1'b1;
    en_EM    = 1'b1;
    en_MW    = 1'b1;
    flush_FD = 1'b0;
    flush_DE = 1'b0;
    flush_EM = 1'b0;
    flush_MW = 1'b0;
    if (exc_M) begin
      flush_FD = 1'b1;
      flush_DE = 1'b1;
      flush_EM = 1'b1;
      flush_MW = 1'b1;
    end else if (stall) begin
      // Hold F and D, insert a bubble into E; E/M/W keep draining.
      en_FD    = 1'b0;
      en_DE    = 1'b0;
      flush_DE = 1'b1;
    end
  end

  assign exc_redirect = (state == EXC);

`ifdef HAZARD_PERF_CNT_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cycles <= '0;
      exc_count    <= '0;
    end else begin
      if (stall && !exc_M && (stall_cycles != '1)) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
      if (exc_M && (state != EXC) && (exc_count != '1)) begin
        exc_count <= exc_count + 16'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire
